// File: rtl/register_file.sv
// register_file
//
// Multi-entry storage with one write port, two independent combinational
// read ports (with same-cycle write bypass), per-entry valid tracking and a
// sequenced clear sweep that zeroes one entry per clock.
//
// Ports:
//   CLK      - clock, rising edge
//   RSTn     - asynchronous active-low reset
//   WE       - write request
//   WAddr    - write address
//   Data     - write data
//   RAddrA/B - read addresses for ports A and B
//   DoutA/B  - read data (0 when the entry holds no written data)
//   ValidA/B - entry at the read address holds written data
//   CLR      - clear-sweep request, sampled at the clock edge
//   Busy     - clear sweep in progress
//   Done     - one-cycle pulse in the cycle after the sweep finishes
//   DbgState - current FSM state (0 = IDLE, 1 = SWEEP)
//
// Write acceptance: a write has no ready/stall path. It is taken on the next
// rising edge when WE is high, no sweep is running, CLR is low and reset is
// released; otherwise it is dropped silently (CLR wins over WE).

module register_file #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             WE,
    input  logic [AW-1:0]    WAddr,
    input  logic [WIDTH-1:0] Data,
    input  logic [AW-1:0]    RAddrA,
    input  logic [AW-1:0]    RAddrB,
    output logic [WIDTH-1:0] DoutA,
    output logic [WIDTH-1:0] DoutB,
    output logic             ValidA,
    output logic             ValidB,
    input  logic             CLR,
    output logic             Busy,
    output logic             Done,
    output logic             DbgState
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      idx;
    logic [DEPTH-1:0]   valid;
    logic               done_q;
    logic               wr_acc;
    logic               sweep_end;
    logic [WIDTH-1:0]   mem [DEPTH];

    assign wr_acc    = RSTn & WE & (state == IDLE) & ~CLR;
    assign sweep_end = (state == SWEEP) && (idx == LAST_IDX);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CLR) state_nxt = SWEEP;
            SWEEP:   if (sweep_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, sweep index, valid vector and Done pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= IDLE;
            idx    <= '0;
            valid  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= sweep_end;
            if (state == SWEEP) begin
                valid[idx] <= 1'b0;
                // Wraps to 0 on the last entry, the same edge that returns to IDLE.
                idx        <= idx + AW'(1);
            end else begin
                idx <= '0;
                if (wr_acc) begin
                    valid[WAddr] <= 1'b1;
                end
            end
        end
    end

    // Data storage has no reset: every read is gated by the valid vector.
    always_ff @(posedge CLK) begin
        if (state == SWEEP) begin
            mem[idx] <= '0;
        end else if (wr_acc) begin
            mem[WAddr] <= Data;
        end
    end

    // Read port A: bypass, then storage, then zero
    always_comb begin
        DoutA  = '0;
        ValidA = 1'b0;
        if (wr_acc && (RAddrA == WAddr)) begin
            DoutA  = Data;
            ValidA = 1'b1;
        end else if (valid[RAddrA]) begin
            DoutA  = mem[RAddrA];
            ValidA = 1'b1;
        end
    end

    // Read port B: identical to port A, fully independent
    always_comb begin
        DoutB  = '0;
        ValidB = 1'b0;
        if (wr_acc && (RAddrB == WAddr)) begin
            DoutB  = Data;
            ValidB = 1'b1;
        end else if (valid[RAddrB]) begin
            DoutB  = mem[RAddrB];
            ValidB = 1'b1;
        end
    end

    assign Busy     = (state == SWEEP);
    assign Done     = done_q;
    assign DbgState = (state == SWEEP);

endmodule
